// File: rtl/dmem_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_write_arbiter                                                       |
// | Shares the dmem write port between the processor and a queued keyboard   |
// | writer with a starvation limit. Optional macro: KBD_COALESCE_EN          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dmem_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_we,
    input  logic [11:0]              cpu_addr,
    input  logic [31:0]              cpu_data,
    output logic                     cpu_stall,
    input  logic                     kbd_we,
    input  logic [11:0]              kbd_addr,
    input  logic [31:0]              kbd_data,
    output logic                     dmem_we,
    output logic [11:0]              dmem_addr,
    output logic [31:0]              dmem_data,
    output logic [$clog2(DEPTH):0]   kbd_pending,
    output logic                     kbd_overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_OCC_W = c_PTR_W + 1;
    localparam int c_CNT_W = $clog2(STARVE_MAX + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_OCC_W-1:0] c_OCC_ZERO = '0;
    localparam logic [c_OCC_W-1:0] c_OCC_ONE  = c_OCC_W'(1);
    localparam logic [c_OCC_W-1:0] c_OCC_FULL = c_OCC_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_STARVE   = c_CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAIN   = 2'd1,
        S_BLOCKED = 2'd2,
        S_FORCE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_kbd_we_q;

    logic [11:0]          r_mem_addr [DEPTH];
    logic [31:0]          r_mem_data [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_OCC_W-1:0]   r_count;
    logic [c_OCC_W-1:0]   w_count_nxt;
    logic                 r_overflow;

    logic                 r_dmem_we;
    logic [11:0]          r_dmem_addr;
    logic [31:0]          r_dmem_data;

    logic                 w_kbd_rise;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_coalesce;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic                 w_grant_cpu;
    logic                 w_stall;
    logic                 w_nonempty_nxt;

    assign w_kbd_rise = kbd_we & ~r_kbd_we_q;
    assign w_empty    = (r_count == c_OCC_ZERO);
    assign w_full     = (r_count == c_OCC_FULL);

`ifdef KBD_COALESCE_EN
    logic [c_PTR_W-1:0] w_tail_idx;
    assign w_tail_idx = r_wr_ptr - c_PTR_ONE;
    // A tail that is also the head leaving this cycle cannot be rewritten.
    assign w_coalesce = w_kbd_rise && !w_empty
                     && (r_mem_addr[w_tail_idx] == kbd_addr)
                     && !(w_pop && (r_count == c_OCC_ONE));
`else
    assign w_coalesce = 1'b0;
`endif

    assign w_push = w_kbd_rise & ~w_coalesce & (~w_full | w_pop);
    assign w_drop = w_kbd_rise & ~w_coalesce & w_full & ~w_pop;

    assign w_count_nxt    = r_count + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_pop};
    assign w_nonempty_nxt = (w_count_nxt != c_OCC_ZERO);

    // Grant, pop and starve counter depend only on state and cpu_we.
    always_comb begin
        w_grant_cpu = 1'b0;
        w_pop       = 1'b0;
        w_stall     = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_grant_cpu = cpu_we;
                w_cnt_nxt   = '0;
            end
            S_DRAIN: begin
                if (cpu_we) begin
                    w_grant_cpu = 1'b1;
                    w_cnt_nxt   = c_CNT_ONE;
                end else begin
                    w_pop = 1'b1;
                end
            end
            S_BLOCKED: begin
                if (cpu_we) begin
                    w_grant_cpu = 1'b1;
                    w_cnt_nxt   = (r_cnt >= c_STARVE) ? r_cnt : r_cnt + c_CNT_ONE;
                end else begin
                    w_pop     = 1'b1;
                    w_cnt_nxt = '0;
                end
            end
            S_FORCE: begin
                w_pop     = 1'b1;
                w_stall   = cpu_we;
                w_cnt_nxt = '0;
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    // The window closes on the processor write that brings the count to the limit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = w_nonempty_nxt ? S_DRAIN : S_IDLE;
            end
            S_DRAIN, S_BLOCKED: begin
                if (w_grant_cpu) begin
                    w_state_nxt = (w_cnt_nxt >= c_STARVE) ? S_FORCE : S_BLOCKED;
                end else begin
                    w_state_nxt = w_nonempty_nxt ? S_DRAIN : S_IDLE;
                end
            end
            S_FORCE: begin
                w_state_nxt = w_nonempty_nxt ? S_DRAIN : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_kbd_we_q <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_kbd_we_q <= kbd_we;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= kbd_addr;
            r_mem_data[r_wr_ptr] <= kbd_data;
        end
`ifdef KBD_COALESCE_EN
        if (w_coalesce) begin
            r_mem_data[w_tail_idx] <= kbd_data;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dmem_we   <= 1'b0;
            r_dmem_addr <= '0;
            r_dmem_data <= '0;
        end else begin
            r_dmem_we <= w_grant_cpu | w_pop;
            if (w_grant_cpu) begin
                r_dmem_addr <= cpu_addr;
                r_dmem_data <= cpu_data;
            end else if (w_pop) begin
                r_dmem_addr <= r_mem_addr[r_rd_ptr];
                r_dmem_data <= r_mem_data[r_rd_ptr];
            end
        end
    end

    assign cpu_stall    = w_stall;
    assign dmem_we      = r_dmem_we;
    assign dmem_addr    = r_dmem_addr;
    assign dmem_data    = r_dmem_data;
    assign kbd_pending  = r_count;
    assign kbd_overflow = r_overflow;

endmodule
`default_nettype wire
